// File: rtl/sim_run_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : sim_run_ctrl                                                  |
// | Purpose  : Run/stop controller for the sccomp CPU: gates cpu_en, counts  |
// |            retired instructions, halts on count/halt_req/PC breakpoint,  |
// |            then streams a register-file snapshot over valid/ready.       |
// | Options  : PC_BREAK_EN enables the PC breakpoint stop source.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module sim_run_ctrl #(
  parameter int CNT_W    = 32,
  parameter int DEF_STOP = 200,
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] stop_limit,
  input  logic             halt_req,
  input  logic             retire,
  input  logic [31:0]      pc,
  input  logic             brk_en,
  input  logic [31:0]      brk_pc,
  output logic             cpu_en,
  output logic [CNT_W-1:0] instr_count,
  output logic [IDX_W-1:0] rf_sel,
  input  logic [31:0]      rf_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [31:0]      dump_data,
  output logic             dump_last,
  output logic             halted,
  output logic [1:0]       stop_cause
);

  localparam logic [CNT_W-1:0] c_DEF_STOP = CNT_W'(DEF_STOP);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] c_CAUSE_NONE  = 2'd0;
  localparam logic [1:0] c_CAUSE_COUNT = 2'd1;
  localparam logic [1:0] c_CAUSE_HALT  = 2'd2;
  localparam logic [1:0] c_CAUSE_BRK   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] w_limit_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;

  logic             w_hit_count;
  logic             w_hit_brk;
  logic             w_hit_halt;
  logic             w_stop;
  logic [1:0]       w_stop_cause;
  logic [CNT_W-1:0] w_limit_eff;
  logic             w_idx_last;

  assign w_limit_eff = (stop_limit == '0) ? c_DEF_STOP : stop_limit;
  assign w_idx_last  = (r_idx == c_LAST_IDX);

  // The stop sources are only acted on in RUN; the FSM qualifies them.
  assign w_hit_count = retire && (r_count == (r_limit - c_CNT_ONE));
  assign w_hit_halt  = halt_req;

`ifdef PC_BREAK_EN
  assign w_hit_brk = retire && brk_en && (pc == brk_pc);
`else
  logic w_unused_brk;
  assign w_hit_brk    = 1'b0;
  assign w_unused_brk = ^{brk_en, brk_pc, pc};
`endif

  assign w_stop = w_hit_count || w_hit_brk || w_hit_halt;

  always_comb begin
    w_stop_cause = c_CAUSE_NONE;
    if (w_hit_count) begin
      w_stop_cause = c_CAUSE_COUNT;
    end else if (w_hit_brk) begin
      w_stop_cause = c_CAUSE_BRK;
    end else if (w_hit_halt) begin
      w_stop_cause = c_CAUSE_HALT;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    w_idx_nxt   = r_idx;
    w_cause_nxt = r_cause;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_count_nxt = '0;
          w_limit_nxt = w_limit_eff;
          w_cause_nxt = c_CAUSE_NONE;
        end
      end
      S_RUN: begin
        if (retire) begin
          w_count_nxt = r_count + c_CNT_ONE;
        end
        if (w_stop) begin
          w_state_nxt = S_DUMP;
          w_idx_nxt   = '0;
          w_cause_nxt = w_stop_cause;
        end
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (w_idx_last) begin
            w_state_nxt = S_DONE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + c_IDX_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_idx   <= '0;
      r_cause <= c_CAUSE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
      r_idx   <= w_idx_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // All outputs decode registered state, so cpu_en is glitch-free.
  assign cpu_en      = (r_state == S_RUN);
  assign dump_valid  = (r_state == S_DUMP);
  assign halted      = (r_state == S_DONE);
  assign instr_count = r_count;
  assign stop_cause  = r_cause;
  assign rf_sel      = r_idx;
  assign dump_idx    = r_idx;
  assign dump_last   = dump_valid && w_idx_last;
  // Register 0 is architecturally zero regardless of what the RF port returns.
  assign dump_data   = (dump_valid && (r_idx != '0)) ? rf_data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_sim_run_ctrl                                               |
// | Purpose  : Randomized self-checking bench for sim_run_ctrl.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sim_run_ctrl;

  localparam int NUM = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] stop_limit;
  logic        halt_req;
  logic        retire;
  logic [31:0] pc;
  logic        brk_en;
  logic [31:0] brk_pc;
  logic        cpu_en;
  logic [31:0] instr_count;
  logic [4:0]  rf_sel;
  logic [31:0] rf_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        halted;
  logic [1:0]  stop_cause;

  logic [31:0] rf_mem [NUM];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rf_data = rf_mem[rf_sel];

  sim_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop_limit(stop_limit),
    .halt_req(halt_req), .retire(retire), .pc(pc), .brk_en(brk_en),
    .brk_pc(brk_pc), .cpu_en(cpu_en), .instr_count(instr_count),
    .rf_sel(rf_sel), .rf_data(rf_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .halted(halted), .stop_cause(stop_cause)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_en"},     64'(cpu_en), 64'd0);
    chk({tag, "_count"},      64'(instr_count), 64'd0);
    chk({tag, "_rf_sel"},     64'(rf_sel), 64'd0);
    chk({tag, "_valid"},      64'(dump_valid), 64'd0);
    chk({tag, "_idx"},        64'(dump_idx), 64'd0);
    chk({tag, "_last"},       64'(dump_last), 64'd0);
    chk({tag, "_halted"},     64'(halted), 64'd0);
    chk({tag, "_cause"},      64'(stop_cause), 64'd0);
  endtask

  // One complete start -> run -> dump -> done transaction.
  // halt_at >= 0 raises halt_req the first cycle the retired count equals it;
  // otherwise halt_req is random with probability halt_pm per mille.
  // abort_at >= 0 pulses rst while that dump index is presented.
  task automatic run_one(input int lim_in, input int ret_pct, input int halt_at,
                         input int halt_pm, input int rdy_pct, input int abort_at,
                         input logic use_brk);
    int  lim;
    int  exp_cnt;
    int  exp_cause;
    int  guard;
    int  e;
    bit  stopped;
    bit  r;
    bit  h;
    bit  hit_c;
    bit  hit_b;

    for (int i = 0; i < NUM; i++) rf_mem[i] = $urandom;
    lim       = (lim_in == 0) ? 200 : lim_in;
    exp_cnt   = 0;
    exp_cause = 0;
    brk_en    = use_brk;
    brk_pc    = 32'h10;

    start      = 1'b1;
    stop_limit = 32'(lim_in);
    retire     = 1'b0;
    halt_req   = 1'b0;
    dump_ready = 1'b0;
    step();
    start      = 1'b0;
    stop_limit = $urandom;
    chk("start_cpu_en", 64'(cpu_en), 64'd1);
    chk("start_count", 64'(instr_count), 64'd0);
    chk("start_cause", 64'(stop_cause), 64'd0);
    chk("start_halted", 64'(halted), 64'd0);

    stopped = 1'b0;
    guard   = 0;
    while (!stopped && guard < 2000) begin
      chk("run_cpu_en", 64'(cpu_en), 64'd1);
      chk("run_count", 64'(instr_count), 64'(exp_cnt));
      r = ($urandom_range(99) < ret_pct);
      h = (halt_at >= 0) ? (exp_cnt == halt_at) : ($urandom_range(999) < halt_pm);
      retire   = r;
      halt_req = h;
      pc       = 32'(exp_cnt * 4);
      start    = ($urandom_range(7) == 0);
      hit_c = r && (exp_cnt + 1 == lim);
`ifdef PC_BREAK_EN
      hit_b = r && use_brk && (pc == brk_pc);
`else
      hit_b = 1'b0;
`endif
      if (r) exp_cnt++;
      if (hit_c)      begin exp_cause = 1; stopped = 1'b1; end
      else if (hit_b) begin exp_cause = 3; stopped = 1'b1; end
      else if (h)     begin exp_cause = 2; stopped = 1'b1; end
      step();
      guard++;
    end
    if (!stopped) chk("run_timeout", 64'd1, 64'd0);

    // First dump cycle directly follows the stop event.
    chk("stop_cpu_en", 64'(cpu_en), 64'd0);
    chk("stop_count", 64'(instr_count), 64'(exp_cnt));
    chk("stop_cause", 64'(stop_cause), 64'(exp_cause));
    chk("stop_valid", 64'(dump_valid), 64'd1);

    e     = 0;
    guard = 0;
    while (e < NUM && guard < 1000) begin
      dump_ready = ($urandom_range(99) < rdy_pct);
      start      = ($urandom_range(7) == 0);
      retire     = $urandom_range(1);
      halt_req   = $urandom_range(1);
      chk("dump_valid", 64'(dump_valid), 64'd1);
      chk("dump_idx", 64'(dump_idx), 64'(e));
      chk("dump_rf_sel", 64'(rf_sel), 64'(e));
      chk("dump_data", 64'(dump_data), (e == 0) ? 64'd0 : 64'(rf_mem[e]));
      chk("dump_last", 64'(dump_last), 64'(e == NUM - 1));
      chk("dump_cpu_en", 64'(cpu_en), 64'd0);
      chk("dump_count", 64'(instr_count), 64'(exp_cnt));
      chk("dump_cause", 64'(stop_cause), 64'(exp_cause));
      if (abort_at == e) begin
        rst = 1'b1;
        step();
        rst        = 1'b0;
        start      = 1'b0;
        retire     = 1'b0;
        halt_req   = 1'b0;
        dump_ready = 1'b0;
        chk_reset_vals("abort");
        return;
      end
      if (dump_ready) e++;
      step();
      guard++;
    end
    if (e < NUM) chk("dump_timeout", 64'd1, 64'd0);
    start      = 1'b0;
    retire     = 1'b0;
    halt_req   = 1'b0;
    dump_ready = 1'b0;
    chk("done_valid", 64'(dump_valid), 64'd0);
    chk("done_halted", 64'(halted), 64'd1);
    chk("done_cpu_en", 64'(cpu_en), 64'd0);
    chk("done_count", 64'(instr_count), 64'(exp_cnt));
    chk("done_cause", 64'(stop_cause), 64'(exp_cause));
    step();
    chk("done_hold_halted", 64'(halted), 64'd1);
    chk("done_hold_count", 64'(instr_count), 64'(exp_cnt));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop_limit = '0;
    halt_req   = 1'b0;
    retire     = 1'b0;
    pc         = '0;
    brk_en     = 1'b0;
    brk_pc     = '0;
    dump_ready = 1'b0;
    for (int i = 0; i < NUM; i++) rf_mem[i] = $urandom;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk_reset_vals("idle");

    // Count stop with limit 4, every cycle retiring, free-flowing dump.
    run_one(4, 100, -1, 0, 100, -1, 1'b0);
    // Zero limit falls back to the default of 200.
    run_one(0, 100, -1, 0, 100, -1, 1'b0);
    // Stalling consumer.
    run_one(9, 70, -1, 0, 50, -1, 1'b0);
    // halt_req coincident with the count stop: count wins.
    run_one(4, 100, 3, 0, 100, -1, 1'b0);
    // halt_req alone at count 7.
    run_one(50, 60, 7, 0, 70, -1, 1'b0);
    // Breakpoint at 0x10 (cause 3 only when the feature is built in).
    run_one(40, 100, -1, 0, 80, -1, 1'b1);
    // Reset while index 9 is presented, then a clean run from IDLE.
    run_one(6, 100, -1, 0, 60, 9, 1'b0);
    run_one(3, 80, -1, 0, 40, -1, 1'b0);
    // Random mix.
    for (int k = 0; k < 8; k++) begin
      run_one($urandom_range(40, 1), $urandom_range(100, 30), -1, 20,
              $urandom_range(100, 20), -1, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
